// File: rtl/tt_um_delay_meter.sv
// Delay-line meter: launches a level edge on uio_out[0] and counts clk cycles until the
// returning edge on ui_in[1] reaches the expected level. The count is read out bytewise on uo_out.
module tt_um_delay_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] start_sync_q, echo_sync_q;
  logic                   start_s_d_q;
  logic                   start_s, echo_s, start_rise;

  logic [1:0]       state_q, state_d;
  logic             launch_q, launch_d;
  logic             expected_q, expected_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [15:0]      result_ext;

  logic unused_ok;
  assign unused_ok = ^{ena, uio_in, ui_in[7:4]};

  assign start_s    = start_sync_q[SYNC_STAGES-1];
  assign echo_s     = echo_sync_q[SYNC_STAGES-1];
  assign start_rise = start_s & ~start_s_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q <= '0;
      echo_sync_q  <= '0;
      start_s_d_q  <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], ui_in[0]};
      echo_sync_q  <= {echo_sync_q[SYNC_STAGES-2:0], ui_in[1]};
      start_s_d_q  <= start_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    launch_d   = launch_q;
    expected_d = expected_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_rise) begin
          state_d   = StLaunch;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StLaunch: begin
        // Compare by level, so a spurious edge left over from reset cannot skew the result.
        launch_d   = ~launch_q;
        expected_d = ~launch_q ^ ui_in[3];
        cnt_d      = '0;
        busy_d     = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (echo_s == expected_q) begin
          result_d = cnt_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StDone;
        end else if (cnt_q == CntMax) begin
          result_d  = CntMax;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      launch_q   <= 1'b0;
      expected_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      launch_q   <= launch_d;
      expected_q <= expected_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  // Zero-extend so the high byte reads 0 for narrow counters.
  assign result_ext = 16'(result_q);

  always_comb begin
    uo_out = ui_in[2] ? result_ext[15:8] : result_ext[7:0];
  end

  assign uio_out = {4'h0, busy_q, timeout_q, done_q, launch_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_delay_meter.sv
// Directed bench for tt_um_delay_meter: loopback and modelled delay paths, timeout, ignored
// restarts, asynchronous reset mid-measurement and byte readout.
module tb_tt_um_delay_meter;

  typedef struct {
    int          mode;      // 0 wire loopback, 1 modelled delay path
    int          dly;
    bit          invp;      // modelled path inverts
    bit          invb;      // ui_in[3]
    logic        exp_launch;
    logic [15:0] exp_res;
  } meas_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, byte_sel, inv_bit;
  logic [7:0] uo_out, uio_out, uio_oe, ui_in;
  logic       echo;

  logic       start8, bsel8;
  logic [7:0] uo8, uio8, oe8, ui8;

  int         mode = 0;
  int         dly = 1;
  bit         invp = 1'b0;
  logic [511:0] pipe = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pipe <= {pipe[510:0], uio_out[0]};

  assign echo  = (mode == 0) ? uio_out[0] : (pipe[dly-1] ^ invp);
  assign ui_in = {4'h0, inv_bit, byte_sel, echo, start};
  assign ui8   = {4'h0, 1'b0, bsel8, 1'b0, start8};

  tt_um_delay_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (8'h00),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  tt_um_delay_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b0),
    .ui_in   (ui8),
    .uo_out  (uo8),
    .uio_in  (8'hA5),
    .uio_out (uio8),
    .uio_oe  (oe8)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (uio_out[1] !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done"}, {15'd0, uio_out[1]}, 16'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_meas(input meas_t m, input string tag);
    mode    = m.mode;
    dly     = m.dly;
    invp    = m.invp;
    inv_bit = m.invb;
    byte_sel = 1'b0;
    repeat (320) @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, " launch"}, {15'd0, uio_out[0]}, {15'd0, m.exp_launch});
    chk({tag, " busy"}, {15'd0, uio_out[3]}, 16'd1);
    start = 1'b0;
    wait_done(tag, 2000);
    chk({tag, " timeout"}, {15'd0, uio_out[2]}, 16'd0);
    chk({tag, " busy_end"}, {15'd0, uio_out[3]}, 16'd0);
    #1 chk({tag, " lo"}, {8'd0, uo_out}, {8'd0, m.exp_res[7:0]});
    byte_sel = 1'b1;
    #1 chk({tag, " hi"}, {8'd0, uo_out}, {8'd0, m.exp_res[15:8]});
    byte_sel = 1'b0;
  endtask

  meas_t tbl[4];

  initial begin
    tbl[0] = '{mode: 0, dly: 1,   invp: 1'b0, invb: 1'b0, exp_launch: 1'b1, exp_res: 16'd2};
    tbl[1] = '{mode: 1, dly: 10,  invp: 1'b1, invb: 1'b1, exp_launch: 1'b0, exp_res: 16'd12};
    tbl[2] = '{mode: 1, dly: 10,  invp: 1'b1, invb: 1'b1, exp_launch: 1'b1, exp_res: 16'd12};
    tbl[3] = '{mode: 1, dly: 300, invp: 1'b0, invb: 1'b0, exp_launch: 1'b0, exp_res: 16'h012E};

    rst_n = 1'b0; start = 1'b0; byte_sel = 1'b0; inv_bit = 1'b0;
    start8 = 1'b0; bsel8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst uio_out", {8'd0, uio_out}, 16'h0000);
    chk("rst uo_out", {8'd0, uo_out}, 16'h0000);
    chk("uio_oe", {8'd0, uio_oe}, 16'h000F);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_meas(tbl[i], $sformatf("meas%0d", i));

    // byte_sel toggling without start leaves the result alone
    for (int i = 0; i < 6; i++) begin
      byte_sel = i[0];
      @(negedge clk);
      chk("bsel done", {15'd0, uio_out[1]}, 16'd1);
      chk("bsel uo", {8'd0, uo_out}, i[0] ? 16'h0001 : 16'h002E);
    end
    byte_sel = 1'b0;

    // Restart during WAIT is ignored
    mode = 1; dly = 20; invp = 1'b0; inv_bit = 1'b0;
    repeat (320) @(negedge clk);
    pulse_start();
    chk("ign launch", {15'd0, uio_out[0]}, 16'd1);
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done("ign", 2000);
    chk("ign launch_end", {15'd0, uio_out[0]}, 16'd1);
    chk("ign lo", {8'd0, uo_out}, 16'd22);
    repeat (10) @(negedge clk);
    chk("ign no restart", {15'd0, uio_out[3]}, 16'd0);

    // Asynchronous reset mid-WAIT
    repeat (320) @(negedge clk);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("pre-rst busy", {15'd0, uio_out[3]}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst uio_out", {8'd0, uio_out}, 16'h0000);
    chk("async rst uo_out", {8'd0, uo_out}, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_meas(tbl[0], "post-rst");

    // Timeout on the 8-bit instance: echo stuck low while expecting high
    bsel8 = 1'b0;
    start8 = 1'b1;
    repeat (4) @(negedge clk);
    start8 = 1'b0;
    chk("to launch", {15'd0, uio8[0]}, 16'd1);
    begin
      int n = 0;
      while (uio8[1] !== 1'b1 && n < 600) begin
        @(negedge clk);
        n++;
      end
    end
    chk("to done", {15'd0, uio8[1]}, 16'd1);
    chk("to timeout", {15'd0, uio8[2]}, 16'd1);
    chk("to busy", {15'd0, uio8[3]}, 16'd0);
    chk("to lo", {8'd0, uo8}, 16'h00FF);
    bsel8 = 1'b1;
    #1 chk("to hi", {8'd0, uo8}, 16'h0000);
    bsel8 = 1'b0;
    start8 = 1'b1;
    repeat (4) @(negedge clk);
    start8 = 1'b0;
    chk("to clr done", {15'd0, uio8[1]}, 16'd0);
    chk("to clr timeout", {15'd0, uio8[2]}, 16'd0);
    chk("to clr busy", {15'd0, uio8[3]}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
